fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction-buffer entries (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port redirect_valid  input  1  one-cycle flush request from execute (branch/jump taken).
REQ-006 SHALL have port redirect_pc  input  32  new fetch address, sampled when redirect_valid=1.
REQ-007 SHALL have ports mmu_read_enable  output  1, mmu_address  output  32, mmu_mem_data_width  output  2, mmu_mem_signed_read  output  1, mmu_write_enable  output  1: request side toward mmu.
REQ-008 SHALL have ports mmu_data_out  input  32 and mmu_mem_ready  input  1: response side from mmu.
REQ-009 SHALL have ports instr_valid  output  1, instr  output  32, instr_pc  output  32, fetch_fault  output  1, instr_ready  input  1: decode handshake.

Function
REQ-010 SHALL drive mmu_write_enable=0, mmu_mem_signed_read=0, mmu_mem_data_width=2'b10 (word) constantly.
REQ-011 SHALL use FSM states IDLE, REQ, DISCARD; reset state IDLE.
REQ-012 IDLE->REQ when buffer has a free slot (counting the pending word) and no fault held; mmu_read_enable=1, mmu_address=fetch_pc in the same cycle.
REQ-013 In REQ SHALL hold mmu_read_enable=1 and mmu_address stable until the cycle mmu_mem_ready=1; that cycle captures {fetch_pc, mmu_data_out} into the buffer and fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-014 On mmu_mem_ready in REQ SHALL re-enter REQ next cycle (back-to-back) if a slot remains, else IDLE.
REQ-015 redirect_valid SHALL in the same edge flush all buffer entries and load fetch_pc=redirect_pc; instr_valid=0 the following cycle.
REQ-016 redirect_valid while in REQ with mmu_mem_ready=0 SHALL go to DISCARD (an MMU access is not cancellable); DISCARD drops the returned word on mmu_mem_ready, then goes to IDLE.
REQ-017 redirect_valid coincident with mmu_mem_ready SHALL drop that word and take the redirect; redirect has priority over capture.
REQ-018 instr_valid=1 whenever buffer non-empty; instr/instr_pc/fetch_fault SHALL show the head entry; head pops when instr_valid&instr_ready.
REQ-019 Push and pop in the same cycle SHALL both occur; full buffer with pop SHALL accept the push.
REQ-020 Buffer full SHALL block new requests; an in-flight request is always guaranteed a slot (REQ-012 reservation).
REQ-021 Latency: mmu_mem_ready at edge N -> instr_valid=1 after edge N (available in cycle N+1) when buffer was empty.

Reset
REQ-022 On reset=1 at a clock edge: state IDLE, fetch_pc=RESET_PC, buffer empty, fault flag 0.
REQ-023 Reset output values: instr_valid=0, mmu_read_enable=0, fetch_fault=0, instr=0, instr_pc=0.
REQ-024 Reset mid-request SHALL abandon the access; mmu_read_enable=0 the cycle after reset.

Configuration
REQ-025 Macro FETCH_MISALIGN_TRAP_EN defined: redirect_pc[1:0]!=0 SHALL issue no MMU access, push one entry {pc=redirect_pc, instr=32'h0000_0013, fetch_fault=1}, and halt fetching until next redirect.
REQ-026 Macro undefined: redirect_pc[1:0] SHALL be forced to 2'b00 and fetch_fault tied 0.

Structure
REQ-027 Package fetch_pkg SHALL hold XLEN=32, MMU width encodings (byte/half/word), NOP_INSTR=32'h0000_0013, FSM state typedef.
REQ-028 Buffer SHALL be sub-module fetch_fifo (DEPTH-entry, {pc,instr,fault}, push/pop/flush, full/empty).

Verification
REQ-029 Reset, mmu_mem_ready asserted 1 cycle after each request, instr_ready=1 -> instr_pc 0,4,8,... with instr=mem words, one per cycle after first.
REQ-030 instr_ready=0 with DEPTH=2 -> exactly 2 words captured, mmu_read_enable=0 afterward; release -> fetch resumes at pc 8.
REQ-031 redirect_valid=1, redirect_pc=32'h100 while REQ waiting 3 cycles for mmu_mem_ready -> stale word dropped, next mmu_address=32'h100, first instr_pc=32'h100.
REQ-032 redirect coincident with mmu_mem_ready -> word dropped, next request to redirect_pc.
REQ-033 FETCH_MISALIGN_TRAP_EN, redirect_pc=32'h102 -> no mmu_read_enable, instr_valid with fetch_fault=1, instr_pc=32'h102, instr=32'h13; undefined -> fetch at 32'h100.
REQ-034 reset asserted during REQ -> next cycle mmu_read_enable=0, instr_valid=0, then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: word size, MMU
// access-width encodings, the NOP used for fault entries and the FSM state type.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] MEM_WIDTH_BYTE = 2'b00;
    localparam logic [1:0] MEM_WIDTH_HALF = 2'b01;
    localparam logic [1:0] MEM_WIDTH_WORD = 2'b10;

    localparam logic [XLEN-1:0] NOP_INSTR       = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP         = 32'h0000_0004;
    localparam logic [XLEN-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } fetch_entry_t;

    // Sequential fetch address; wraps naturally at the top of the address space.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding {pc, instr, fault} entries. Flush empties it
// in one edge; a push in the same edge as a flush lands as the sole entry.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output fetch_entry_t             head_entry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_idx;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;
    logic             rd_en;
    fetch_entry_t     entry_bank [DEPTH];

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign head_entry = entry_bank[rd_ptr_q];

    always_comb begin
        rd_en  = pop && !empty && !flush;
        // A full buffer still accepts a push when the head leaves in the same edge.
        wr_en  = push && (flush || !full || rd_en);
        wr_idx = flush ? '0 : wr_ptr_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = wr_en ? PTR_W'(1) : '0;
            count_d  = wr_en ? CNT_W'(1) : '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
            wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
            count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_q <= '0;
                end else if (wr_en && (wr_idx == PTR_W'(gi))) begin
                    entry_q <= push_entry;
                end
            end
            assign entry_bank[gi] = entry_q;
        end
    endgenerate

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word reads to the MMU, buffers returned words
// for decode and handles redirects. Optional FETCH_MISALIGN_TRAP_EN turns
// misaligned redirect targets into a single faulting NOP entry.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             mmu_read_enable,
    output logic [XLEN-1:0]  mmu_address,
    output logic [1:0]       mmu_mem_data_width,
    output logic             mmu_mem_signed_read,
    output logic             mmu_write_enable,
    input  logic [XLEN-1:0]  mmu_data_out,
    input  logic             mmu_mem_ready,
    output logic             instr_valid,
    output logic [XLEN-1:0]  instr,
    output logic [XLEN-1:0]  instr_pc,
    output logic             fetch_fault,
    input  logic             instr_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  hold_addr_q, hold_addr_d;
    logic             fault_q, fault_d;

    logic [XLEN-1:0]  redirect_target;
    logic             trap_push;
    logic             capture;
    logic             slot_free;
    logic             can_fetch;
    int               occupancy;

    logic             buf_push;
    logic             buf_pop;
    logic             buf_full;
    logic             buf_empty;
    logic [CNT_W-1:0] buf_count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_target = redirect_pc;
    assign trap_push       = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Set by a misaligned redirect; blocks fetching until the next redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign redirect_target = redirect_pc & WORD_ALIGN_MASK;
    assign trap_push       = 1'b0;
    assign fault_q         = 1'b0;
`endif

    assign fault_d = redirect_valid ? trap_push : fault_q;

    assign mmu_write_enable    = 1'b0;
    assign mmu_mem_signed_read = 1'b0;
    assign mmu_mem_data_width  = MEM_WIDTH_WORD;

    // Redirect wins over capture: a word returning in a redirect cycle is dropped.
    assign capture  = (state_q == ST_REQ) && mmu_mem_ready && !redirect_valid;
    assign buf_push = capture || trap_push;
    assign buf_pop  = !buf_empty && instr_ready && !redirect_valid;

    always_comb begin
        if (trap_push) begin
            push_entry = '{pc: redirect_pc, instr: NOP_INSTR, fault: 1'b1};
        end else begin
            push_entry = '{pc: fetch_pc_q, instr: mmu_data_out, fault: 1'b0};
        end
    end

    // A new request may only start if its word is guaranteed a slot after this edge.
    always_comb begin
        occupancy = 0;
        if (redirect_valid) begin
            slot_free = 1'b1;
        end else if (capture) begin
            occupancy = int'(buf_count) + 1 - (buf_pop ? 1 : 0);
            slot_free = (occupancy < DEPTH);
        end else begin
            slot_free = !buf_full || buf_pop;
        end
        can_fetch = slot_free && !fault_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (can_fetch) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mmu_mem_ready) begin
                    state_d = can_fetch ? ST_REQ : ST_IDLE;
                end else if (redirect_valid) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (mmu_mem_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mmu_read_enable = (state_q != ST_IDLE);
        // The abandoned access keeps its original address until the MMU completes it.
        mmu_address     = (state_q == ST_DISCARD) ? hold_addr_q : fetch_pc_q;
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        hold_addr_d = hold_addr_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
        end else if (capture) begin
            fetch_pc_d = next_pc(fetch_pc_q);
        end
        if ((state_q == ST_REQ) && (state_d == ST_DISCARD)) begin
            hold_addr_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            hold_addr_q <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            hold_addr_q <= hold_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (buf_push),
        .push_entry (push_entry),
        .pop        (buf_pop),
        .head_entry (head_entry),
        .full       (buf_full),
        .empty      (buf_empty),
        .count      (buf_count)
    );

    // Without the trap option the fault bit is only ever written as 0.
    assign instr_valid = !buf_empty;
    assign instr       = buf_empty ? '0 : head_entry.instr;
    assign instr_pc    = buf_empty ? '0 : head_entry.pc;
    assign fetch_fault = !buf_empty && head_entry.fault;

endmodule
